// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit RISC datapath: the instruction word
// width, per-field widths and bit positions, and the field typedefs used by
// the instruction register and the control unit.
package isa_pkg;

    localparam int FIELD_W  = 4;
    localparam int IR_WIDTH = 4 * FIELD_W;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int DA_MSB  = 11;
    localparam int DA_LSB  = 8;
    localparam int AA_MSB  = 7;
    localparam int AA_LSB  = 4;
    localparam int BA_MSB  = 3;
    localparam int BA_LSB  = 0;

    typedef logic [FIELD_W-1:0]  opcode_t;
    typedef logic [FIELD_W-1:0]  reg_addr_t;
    typedef logic [IR_WIDTH-1:0] ir_word_t;

endpackage : isa_pkg

// File: rtl/ir_field_split.sv
// Purely combinational split of an instruction word into opcode, DA, AA and
// BA. Kept as its own module so the control unit slices words identically.
module ir_field_split
    import isa_pkg::*;
(
    input  ir_word_t  word,
    output opcode_t   opcode,
    output reg_addr_t da,
    output reg_addr_t aa,
    output reg_addr_t ba
);

    assign opcode = word[OPC_MSB:OPC_LSB];
    assign da     = word[DA_MSB:DA_LSB];
    assign aa     = word[AA_MSB:AA_LSB];
    assign ba     = word[BA_MSB:BA_LSB];

endmodule : ir_field_split

// File: rtl/instruction_register.sv
// Instruction register: captures the fetched word when IL is high and
// presents its four fields to decode and the register file. Outputs are
// slices of the stored word only, so IR/IL never reach them combinationally.
// The reset input is asynchronous and active-low (0 clears the register).
// Optional feature: define INSTR_REG_VALID_EN to add ir_valid, which goes
// high on the first load after reset so decode can ignore the zero word.
module instruction_register
    import isa_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      IL,
    input  ir_word_t  IR,
    output opcode_t   opcode,
    output reg_addr_t DA,
    output reg_addr_t AA,
    output reg_addr_t BA
`ifdef INSTR_REG_VALID_EN
    ,
    output logic      ir_valid
`endif
);

    ir_word_t ir_d;
    ir_word_t ir_q;

    // Next word: take the incoming instruction on a load, otherwise hold.
    always_comb begin
        ir_d = ir_q;
        if (IL) begin
            ir_d = IR;
        end
    end

    // Word register; reset clears it immediately without waiting for clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

`ifdef INSTR_REG_VALID_EN
    logic valid_d;
    logic valid_q;

    // Valid becomes sticky on the first load and only reset clears it.
    always_comb begin
        valid_d = valid_q;
        if (IL) begin
            valid_d = 1'b1;
        end
    end

    // Valid flag register, cleared together with the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign ir_valid = valid_q;
`endif

    ir_field_split u_split (
        .word   (ir_q),
        .opcode (opcode),
        .da     (DA),
        .aa     (AA),
        .ba     (BA)
    );

endmodule : instruction_register

// File: tb/tb_instruction_register.sv
// Testbench for instruction_register. The reference model keeps the history
// of words loaded since the last reset; the expected word is the most recent
// entry, or zero when nothing has been loaded yet.
// Build with INSTR_REG_VALID_EN defined to also cover ir_valid.
module tb_instruction_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        IL;
    logic [15:0] IR;
    logic [3:0]  opcode;
    logic [3:0]  DA;
    logic [3:0]  AA;
    logic [3:0]  BA;
`ifdef INSTR_REG_VALID_EN
    logic        ir_valid;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] history[$];

    instruction_register dut (
        .clk      (clk),
        .reset    (reset),
        .IL       (IL),
        .IR       (IR),
        .opcode   (opcode),
        .DA       (DA),
        .AA       (AA),
        .BA       (BA)
`ifdef INSTR_REG_VALID_EN
        ,
        .ir_valid (ir_valid)
`endif
    );

    // Free-running 10 ns clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Model: every accepted load appends the word to the history.
    always @(posedge clk) begin
        if (reset === 1'b1 && IL === 1'b1) begin
            history.push_back(IR);
        end
    end

    // Model: reset forgets everything loaded so far, at once.
    always @(negedge reset) begin
        history.delete();
    end

    function automatic logic [15:0] expectedWord();
        if (history.size() == 0) return 16'h0000;
        return history[history.size() - 1];
    endfunction

    task automatic checkField(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eo, input logic [3:0] ed,
                               input logic [3:0] ea, input logic [3:0] eb);
        checkField({tag, ".opcode"}, opcode, eo);
        checkField({tag, ".DA"}, DA, ed);
        checkField({tag, ".AA"}, AA, ea);
        checkField({tag, ".BA"}, BA, eb);
    endtask

    task automatic checkValid(input string tag, input logic expected);
`ifdef INSTR_REG_VALID_EN
        checks++;
        if (ir_valid !== expected) begin
            errors++;
            $display("[TB] FAIL %s.ir_valid at %0t: got %b, expected %b", tag, $time, ir_valid, expected);
        end
`endif
    endtask

    task automatic checkModel(input string tag, input logic [15:0] expected);
        logic [15:0] w;
        w = expectedWord();
        checks++;
        if (w !== expected) begin
            errors++;
            $display("[TB] FAIL %s.model at %0t: got %h, expected %h", tag, $time, w, expected);
        end
    endtask

    // Compare DUT fields against the model on every falling edge.
    always @(negedge clk) begin
        logic [15:0] w;
        w = expectedWord();
        checkOutput("cycle", 4'((w >> 12) & 16'hF), 4'((w >> 8) & 16'hF),
                    4'((w >> 4) & 16'hF), 4'(w & 16'hF));
        checkValid("cycle", history.size() != 0);
    end

    task automatic applyStimulus(input logic rst_v, input logic il_v, input logic [15:0] ir_v);
        reset = rst_v;
        IL    = il_v;
        IR    = ir_v;
    endtask

    // Directed scenarios with literal expectations, then a randomized run.
    initial begin
        applyStimulus(1'b0, 1'b1, 16'h8006);
        #10;
        checkOutput("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);
        checkValid("reset_hold", 1'b0);
        reset = 1'b1;

        @(posedge clk); #1;
        checkOutput("first_load", 4'h8, 4'h0, 4'h0, 4'h6);
        checkValid("first_load", 1'b1);
        checkModel("first_load", 16'h8006);

        applyStimulus(1'b1, 1'b0, 16'h1234);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("hold", 4'h8, 4'h0, 4'h0, 4'h6);

        applyStimulus(1'b1, 1'b1, 16'h1234);
        @(posedge clk); #1;
        checkOutput("load_1234", 4'h1, 4'h2, 4'h3, 4'h4);
        IR = 16'hFEDC;
        @(posedge clk); #1;
        checkOutput("load_fedc", 4'hF, 4'hE, 4'hD, 4'hC);
        checkModel("load_fedc", 16'hFEDC);

        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 4'h0, 4'h0, 4'h0, 4'h0);
        checkValid("async_reset", 1'b0);
        IR = 16'hA5C3;
        IL = 1'b1;
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_load", 4'hA, 4'h5, 4'hC, 4'h3);
        checkValid("release_load", 1'b1);

        IL = 1'b0;
        @(posedge clk); #1;
        checkValid("valid_sticky", 1'b1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #3;
            applyStimulus(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        applyStimulus(1'b1, 1'b0, 16'h0000);
        @(posedge clk);
        #7;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instruction_register
